// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types for the instruction fetch buffer: the queued entry payload,
// the request-tracking state encoding and the architectural reset PC.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int unsigned FETCH_WORD_W = 32;
  localparam int unsigned FETCH_PC_W   = 32;

  localparam logic [FETCH_PC_W-1:0] RESET_PC = 32'h0000_3000;

  // One queued fetch result as seen by decode
  typedef struct packed {
    logic [FETCH_WORD_W-1:0] word;
    logic [FETCH_PC_W-1:0]   pc;
    logic                    fault;
  } fetch_entry_t;

  // Request tracking: no request, request outstanding, request to be dropped
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    DISCARD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch_entry_t. The head entry is read straight out of
// the storage registers, so the head outputs never depend combinationally on
// push_data. clear empties the queue and dominates a same-cycle push or pop.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   push, push_data   enqueue one entry
//   pop               dequeue the head entry (ignored when empty)
//   clear             drop all queued entries
//   head              current head entry
//   count             number of queued entries (0..DEPTH)
//   full, empty       occupancy flags
// -----------------------------------------------------------------------------
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  input  logic                   clear,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  assign do_pop  = pop & ~empty & ~clear;
  assign do_push = push & ~clear & (~full | do_pop);

  // Next-state: pointers wrap naturally because DEPTH is a power of two
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      unique case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Storage and pointer registers
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// instr_fetch_buffer
// Takes PCs over a valid/ready handshake, issues one outstanding instruction
// memory read per PC over req/ack, and queues {word, pc, fault} for decode.
// flush drops everything queued and discards the in-flight response.
//
// Optional feature (macro FETCH_ALIGN_CHECK_EN): a PC with nonzero low two
// bits is not sent to memory; a fault entry {0, pc, 1} is queued instead.
// Without the macro misaligned PCs go to memory unchanged, inst_fault is 0.
//
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   pc_valid/pc_ready/pc_in PC offer from the program counter (pc_ready comb.)
//   imem_req/imem_addr      registered memory read request
//   imem_ack/imem_rdata     read completion and instruction word
//   flush                   redirect from branch/jump resolution
//   inst_valid/inst_ready   decode handshake on the FIFO head
//   inst_word/inst_pc       head instruction and its PC
//   inst_fault              head is a misaligned-PC fault
// -----------------------------------------------------------------------------
module instr_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pc_valid,
  output logic              pc_ready,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  input  logic              flush,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst_word,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_fault
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e      state_q, state_d;
  logic              imem_req_q, imem_req_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;

  logic              accept;
  logic              misaligned;
  logic              fault_pend;
  logic              push;
  logic              pop;
  fetch_entry_t      push_data;
  fetch_entry_t      head;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  slots_used;
  logic              fifo_full;
  logic              fifo_empty;

`ifdef FETCH_ALIGN_CHECK_EN
  logic              fault_pend_q, fault_pend_d;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;

  assign misaligned = (pc_in[1:0] != 2'b00);
  assign fault_pend = fault_pend_q;
`else
  assign misaligned = 1'b0;
  assign fault_pend = 1'b0;
`endif

  // A fault entry waiting to be pushed already owns a FIFO slot
  assign slots_used = fifo_count + CNT_W'(fault_pend);
  assign pc_ready   = (state_q == IDLE) & ~flush & ~fifo_full &
                      (slots_used < CNT_W'(DEPTH));
  assign accept     = pc_valid & pc_ready;
  assign pop        = inst_ready & ~fifo_empty;

  // Request tracking and push generation
  always_comb begin
    state_d     = state_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;
    push        = 1'b0;
    push_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (accept && !misaligned) begin
          imem_req_d  = 1'b1;
          imem_addr_d = pc_in;
          state_d     = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = IDLE;
          if (!flush) begin
            push            = 1'b1;
            push_data.word  = imem_rdata;
            push_data.pc    = FETCH_PC_W'(imem_addr_q);
            push_data.fault = 1'b0;
          end
        end else if (flush) begin
          // Request must stay up until memory answers; its data is dropped
          state_d = DISCARD;
        end
      end
      DISCARD: begin
        if (imem_ack) begin
          imem_req_d = 1'b0;
          state_d    = IDLE;
        end
      end
      default: begin
        imem_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase

`ifdef FETCH_ALIGN_CHECK_EN
    fault_pend_d = 1'b0;
    fault_pc_d   = fault_pc_q;
    // Never coincides with a memory push: a WAIT ack needs at least one
    // more cycle after the accept that follows a fault
    if (fault_pend_q) begin
      push            = 1'b1;
      push_data.word  = '0;
      push_data.pc    = FETCH_PC_W'(fault_pc_q);
      push_data.fault = 1'b1;
    end
    if (state_q == IDLE && accept && misaligned) begin
      fault_pend_d = 1'b1;
      fault_pc_d   = pc_in;
    end
`endif
  end

  // State and request registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Pending misaligned-PC fault
  always_ff @(posedge clock) begin
    if (reset) begin
      fault_pend_q <= 1'b0;
      fault_pc_q   <= '0;
    end else begin
      fault_pend_q <= fault_pend_d;
      fault_pc_q   <= fault_pc_d;
    end
  end
`endif

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .clear     (flush),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = ~fifo_empty;
  assign inst_word  = head.word;
  assign inst_pc    = ADDR_W'(head.pc);

`ifdef FETCH_ALIGN_CHECK_EN
  assign inst_fault = head.fault;
`else
  logic unused_head_fault;
  assign unused_head_fault = head.fault;
  assign inst_fault        = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_buffer
// Self-checking bench: a vector table of single fetches plus hand-written
// sequences for backpressure, flush and reset corners. A scoreboard queue
// receives the expected entry at every PC accept and is compared on every
// decode pop. Inputs change on the falling edge; outputs are sampled 4 ns
// later, just before the rising edge that acts on them.
// -----------------------------------------------------------------------------
module tb_instr_fetch_buffer;

  logic        clock;
  logic        reset;
  logic        pc_valid;
  logic        pc_ready;
  logic [31:0] pc_in;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_word;
  logic [31:0] inst_pc;
  logic        inst_fault;

  instr_fetch_buffer #(
    .DEPTH  (4),
    .ADDR_W (32)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .pc_valid   (pc_valid),
    .pc_ready   (pc_ready),
    .pc_in      (pc_in),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .flush      (flush),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst_word  (inst_word),
    .inst_pc    (inst_pc),
    .inst_fault (inst_fault)
  );

  typedef struct {
    logic [31:0] word;
    logic [31:0] pc;
    logic        fault;
  } exp_t;

  typedef struct {
    logic [31:0] pc;
    int          delay;
    bit          exp_req;
    int          exp_lat;
    bit          exp_fault;
  } vec_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   ack_delay = 0;
  int   wait_cnt  = 0;
  bit   mem_en    = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1F2E};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Memory responder: acks a request after ack_delay cycles of it being up
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    forever begin
      @(negedge clock);
      if (mem_en) begin
        if (imem_ack) begin
          imem_ack   = 1'b0;
          imem_rdata = 32'hDEAD_BEEF;
          wait_cnt   = 0;
        end else if (imem_req) begin
          if (wait_cnt >= ack_delay) begin
            imem_ack   = 1'b1;
            imem_rdata = mem_word(imem_addr);
          end else begin
            wait_cnt++;
          end
        end else begin
          wait_cnt = 0;
        end
      end
    end
  end

  // Scoreboard monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      #4;
      if (reset || flush) begin
        sb.delete();
      end else begin
        if (inst_valid && inst_ready) begin
          if (sb.size() == 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL sb_pop: got pc %0h with no expected entry", inst_pc);
          end else begin
            e = sb.pop_front();
            check("sb_word",  64'(inst_word),  64'(e.word));
            check("sb_pc",    64'(inst_pc),    64'(e.pc));
            check("sb_fault", 64'(inst_fault), 64'(e.fault));
          end
        end
        if (pc_valid && pc_ready) begin
          e.pc = pc_in;
`ifdef FETCH_ALIGN_CHECK_EN
          if (pc_in[1:0] != 2'b00) begin
            e.word  = 32'h0;
            e.fault = 1'b1;
          end else begin
            e.word  = mem_word(pc_in);
            e.fault = 1'b0;
          end
`else
          e.word  = mem_word(pc_in);
          e.fault = 1'b0;
`endif
          sb.push_back(e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Offer one PC; returns at a falling edge with pc_valid dropped
  task automatic send_pc(input logic [31:0] pc, input int max_cyc,
                         output bit ok, output int acc_cyc);
    ok      = 1'b0;
    acc_cyc = 0;
    @(negedge clock);
    pc_valid = 1'b1;
    pc_in    = pc;
    for (int k = 0; k < max_cyc; k++) begin
      #4;
      if (pc_ready) begin
        ok      = 1'b1;
        acc_cyc = cyc;
        break;
      end
      @(negedge clock);
    end
    if (ok) @(negedge clock);
    pc_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    @(negedge clock);
    inst_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      #4;
      if (!inst_valid && sb.size() == 0) begin
        done = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check(name, 64'(done), 64'd1);
    @(negedge clock);
  endtask

  vec_t vecs[7];

  initial begin
    bit ok;
    bit got;
    int acc;

    vecs[0] = '{pc: 32'h3000, delay: 0, exp_req: 1'b1, exp_lat: 2, exp_fault: 1'b0};
    vecs[1] = '{pc: 32'h3004, delay: 0, exp_req: 1'b1, exp_lat: 2, exp_fault: 1'b0};
    vecs[2] = '{pc: 32'h3008, delay: 0, exp_req: 1'b1, exp_lat: 2, exp_fault: 1'b0};
    vecs[3] = '{pc: 32'h300C, delay: 1, exp_req: 1'b1, exp_lat: 3, exp_fault: 1'b0};
    vecs[4] = '{pc: 32'h3010, delay: 3, exp_req: 1'b1, exp_lat: 5, exp_fault: 1'b0};
`ifdef FETCH_ALIGN_CHECK_EN
    vecs[5] = '{pc: 32'h3002, delay: 2, exp_req: 1'b0, exp_lat: 2, exp_fault: 1'b1};
`else
    vecs[5] = '{pc: 32'h3002, delay: 2, exp_req: 1'b1, exp_lat: 4, exp_fault: 1'b0};
`endif
    vecs[6] = '{pc: 32'h3014, delay: 2, exp_req: 1'b1, exp_lat: 4, exp_fault: 1'b0};

    reset      = 1'b1;
    pc_valid   = 1'b0;
    pc_in      = 32'h0;
    flush      = 1'b0;
    inst_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clock);
    #4;
    check("rst_imem_req",   64'(imem_req),   64'd0);
    check("rst_imem_addr",  64'(imem_addr),  64'd0);
    check("rst_inst_valid", 64'(inst_valid), 64'd0);
    check("rst_inst_word",  64'(inst_word),  64'd0);
    check("rst_inst_pc",    64'(inst_pc),    64'd0);
    check("rst_inst_fault", 64'(inst_fault), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #4;
    check("rst_pc_ready", 64'(pc_ready), 64'd1);

    // Table of single fetches with decode always ready
    inst_ready = 1'b1;
    foreach (vecs[i]) begin
      ack_delay = vecs[i].delay;
      send_pc(vecs[i].pc, 10, ok, acc);
      check("vec_accept", 64'(ok), 64'd1);
      #4;
      check("vec_req", 64'(imem_req), 64'(vecs[i].exp_req));
      if (vecs[i].exp_req) check("vec_addr", 64'(imem_addr), 64'(vecs[i].pc));
      got = 1'b0;
      for (int k = 0; k < 20; k++) begin
        if (inst_valid) begin
          got = 1'b1;
          break;
        end
        @(negedge clock);
        #4;
      end
      check("vec_valid_seen", 64'(got), 64'd1);
      check("vec_latency",    64'(cyc - acc), 64'(vecs[i].exp_lat));
      check("vec_fault",      64'(inst_fault), 64'(vecs[i].exp_fault));
      @(negedge clock);
    end
    drain("vec_drain");

    // Backpressure: four accepted, the rest stalled until a pop
    ack_delay  = 0;
    inst_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send_pc(32'h5000 + 32'(4 * i), 6, ok, acc);
      check("bp_accept", 64'(ok), (i < 4) ? 64'd1 : 64'd0);
    end
    #4;
    check("bp_pc_ready_low", 64'(pc_ready), 64'd0);
    check("bp_full_valid",   64'(inst_valid), 64'd1);
    @(negedge clock);
    inst_ready = 1'b1;
    @(negedge clock);
    inst_ready = 1'b0;
    send_pc(32'h5010, 6, ok, acc);
    check("bp_accept_after_pop", 64'(ok), 64'd1);
    drain("bp_drain");

    // Flush while waiting; ack arrives three cycles later and is dropped
    inst_ready = 1'b1;
    ack_delay  = 3;
    send_pc(32'h3100, 10, ok, acc);
    check("fw_accept", 64'(ok), 64'd1);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #4;
      check("fw_req_hold", 64'(imem_req), (k < 3) ? 64'd1 : 64'd0);
      check("fw_no_valid", 64'(inst_valid), 64'd0);
      @(negedge clock);
    end
    ack_delay = 0;
    send_pc(32'h4000, 10, ok, acc);
    check("fw_next_accept", 64'(ok), 64'd1);
    #4;
    #10;
    check("fw_next_valid", 64'(inst_valid), 64'd1);
    check("fw_next_pc",    64'(inst_pc),    64'h4000);
    drain("fw_drain");

    // Flush coincident with ack
    ack_delay = 1;
    send_pc(32'h3200, 10, ok, acc);
    @(negedge clock);
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    #4;
    check("fa_req_low",   64'(imem_req),   64'd0);
    check("fa_no_valid",  64'(inst_valid), 64'd0);
    check("fa_pc_ready",  64'(pc_ready),   64'd1);
    #10;
    check("fa_no_valid2", 64'(inst_valid), 64'd0);

    // Flush with a full FIFO and a same-cycle pop
    ack_delay  = 0;
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send_pc(32'h6000 + 32'(4 * i), 6, ok, acc);
      check("ff_accept", 64'(ok), 64'd1);
    end
    @(negedge clock);
    flush      = 1'b1;
    inst_ready = 1'b1;
    #4;
    check("ff_full_valid",   64'(inst_valid), 64'd1);
    check("ff_flush_noready", 64'(pc_ready),  64'd0);
    @(negedge clock);
    flush      = 1'b0;
    inst_ready = 1'b0;
    #4;
    check("ff_empty",    64'(inst_valid), 64'd0);
    check("ff_pc_ready", 64'(pc_ready),   64'd1);

    // Reset during WAIT, then a stray ack
    ack_delay = 5;
    send_pc(32'h3300, 10, ok, acc);
    check("rw_accept", 64'(ok), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    #4;
    check("rw_req_low",  64'(imem_req),   64'd0);
    check("rw_no_valid", 64'(inst_valid), 64'd0);
    @(negedge clock);
    mem_en     = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'h1234_5678;
    @(negedge clock);
    imem_ack   = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      #4;
      check("rw_stray_valid", 64'(inst_valid), 64'd0);
      check("rw_stray_req",   64'(imem_req),   64'd0);
      @(negedge clock);
    end
    wait_cnt  = 0;
    mem_en    = 1'b1;
    ack_delay = 0;

    // Fetch still works after the stray ack
    inst_ready = 1'b1;
    send_pc(32'h3400, 10, ok, acc);
    check("post_accept", 64'(ok), 64'd1);
    drain("post_drain");
    check("sb_empty_end", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
